// File: rtl/priority_arbiter_4.sv
// priority_arbiter_4: 4-way arbiter with grant hold limit, one-cycle release gap and forced preemption.
// Define PRIORITY_ARBITER_ROUND_ROBIN_EN to rotate the search start after each grant instead of fixed priority.
module priority_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_vld,
  output logic       preempt
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  localparam logic [7:0] MH = 8'(MAX_HOLD);
  state_t state_q, state_d;
  logic [1:0] owner_q, owner_d, gnt_id_q, gnt_id_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d, owner_oh, cand;
  logic gnt_vld_q, gnt_vld_d, preempt_q, preempt_d, others, any;
  logic [1:0] start, idx, win;
`ifdef PRIORITY_ARBITER_ROUND_ROBIN_EN
  logic [1:0] last_owner_q, last_owner_d;
  assign start = last_owner_q - 2'd1;
`else
  assign start = 2'd3;
`endif
  assign owner_oh = 4'b0001 << owner_q;
  assign others = |(req & ~owner_oh);
  // after a forced release the old owner steps aside only if someone else is waiting
  assign cand = req & ((state_q == GAP && preempt_q && others) ? ~owner_oh : 4'hf);
  assign any = |cand;
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = start - 2'(k);
      if (cand[idx]) win = idx;
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d = hold_q;
    gnt_d = '0;
    gnt_vld_d = 1'b0;
    gnt_id_d = gnt_id_q;
    preempt_d = 1'b0;
`ifdef PRIORITY_ARBITER_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      GRANT: begin
        if (!req[owner_q]) begin
          state_d = GAP;
        end else if (hold_q == MH && others) begin
          state_d = GAP;
          preempt_d = 1'b1;
        end else begin
          gnt_d = owner_oh;
          gnt_vld_d = 1'b1;
          hold_d = (hold_q == MH) ? hold_q : hold_q + 8'd1;
        end
      end
      default: begin
        if (any) begin
          state_d = GRANT;
          owner_d = win;
          hold_d = 8'd1;
          gnt_d = 4'b0001 << win;
          gnt_vld_d = 1'b1;
          gnt_id_d = win;
`ifdef PRIORITY_ARBITER_ROUND_ROBIN_EN
          last_owner_d = win;
`endif
        end else begin
          state_d = IDLE;
          hold_d = 8'd0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      hold_q <= '0;
      gnt_q <= '0;
      gnt_vld_q <= 1'b0;
      gnt_id_q <= '0;
      preempt_q <= 1'b0;
`ifdef PRIORITY_ARBITER_ROUND_ROBIN_EN
      last_owner_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q <= hold_d;
      gnt_q <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_id_q <= gnt_id_d;
      preempt_q <= preempt_d;
`ifdef PRIORITY_ARBITER_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end
  assign gnt = gnt_q;
  assign gnt_id = gnt_id_q;
  assign gnt_vld = gnt_vld_q;
  assign preempt = preempt_q;
endmodule

// File: tb/tb_priority_arbiter_4.sv
// tb_priority_arbiter_4: directed-vector bench for priority_arbiter_4 built with MAX_HOLD=4.
module tb_priority_arbiter_4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic gnt_vld, preempt;
  int n_chk = 0;
  int n_fail = 0;
  priority_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .preempt(preempt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id, input logic p);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".vld"}, 32'(gnt_vld), 32'(g != 4'b0));
    check({tag, ".id"}, 32'(gnt_id), 32'(id));
    check({tag, ".pre"}, 32'(preempt), 32'(p));
    check({tag, ".oh"}, 32'($onehot0(gnt)), 32'd1);
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  initial begin
    repeat (2) cyc();
    expect_out("reset", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    // basic grant, release, gap, next winner
    req = 4'b0110;
    cyc(); expect_out("t1.g2", 4'b0100, 2'd2, 1'b0);
    req = 4'b0010;
    cyc(); expect_out("t1.gap", 4'b0000, 2'd2, 1'b0);
    cyc(); expect_out("t1.g1", 4'b0010, 2'd1, 1'b0);
    req = 4'b0000;
    cyc(); expect_out("t1.gap2", 4'b0000, 2'd1, 1'b0);
    cyc(); expect_out("t1.idle", 4'b0000, 2'd1, 1'b0);
    // forced release after MAX_HOLD
    req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      cyc(); expect_out("t2.hold", 4'b1000, 2'd3, 1'b0);
    end
    cyc(); expect_out("t2.gap", 4'b0000, 2'd3, 1'b1);
    cyc(); expect_out("t2.g0", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    cyc(); expect_out("t2.gap2", 4'b0000, 2'd0, 1'b0);
    cyc(); expect_out("t2.idle", 4'b0000, 2'd0, 1'b0);
    // sole requester keeps the grant past MAX_HOLD
    req = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      cyc(); expect_out("t3.hold", 4'b1000, 2'd3, 1'b0);
    end
    req = 4'b0000;
    cyc(); expect_out("t3.gap", 4'b0000, 2'd3, 1'b0);
    cyc(); expect_out("t3.idle", 4'b0000, 2'd3, 1'b0);
    // no mid-grant switch to a higher priority requester
    req = 4'b0001;
    cyc(); expect_out("t4.g0", 4'b0001, 2'd0, 1'b0);
    req = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      cyc(); expect_out("t4.keep", 4'b0001, 2'd0, 1'b0);
    end
    req = 4'b1000;
    cyc(); expect_out("t4.gap", 4'b0000, 2'd0, 1'b0);
    cyc(); expect_out("t4.g3", 4'b1000, 2'd3, 1'b0);
    req = 4'b0000;
    cyc(); cyc();
    // asynchronous reset mid-grant
    req = 4'b0100;
    cyc(); expect_out("t5.g2", 4'b0100, 2'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1 expect_out("t5.async", 4'b0000, 2'd0, 1'b0);
    req = 4'b0010;
    cyc(); expect_out("t5.inrst", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    cyc(); expect_out("t5.g1", 4'b0010, 2'd1, 1'b0);
`ifdef PRIORITY_ARBITER_ROUND_ROBIN_EN
    begin
      logic [3:0] seq [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
      logic [1:0] ids [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
      req = 4'b0000;
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
        cyc(); expect_out("t6.rr", seq[i], ids[i], 1'b0);
        req = 4'b1111 & ~seq[i];
        cyc(); expect_out("t6.gap", 4'b0000, ids[i], 1'b0);
        req = 4'b1111;
      end
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/priority_arbiter_4.md
PRIORITY_ARBITER_4 -- requirements
Module: priority_arbiter_4

Interface
REQ-001 SHALL have parameter: MAX_HOLD, default 8, maximum consecutive grant cycles before forced release when others wait (legal 1..255).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req  input  4  request per requester, level, held until done with resource.
REQ-005 SHALL have port: gnt  output  4  one-hot grant, registered.
REQ-006 SHALL have port: gnt_id  output  2  binary index of granted requester, valid only when gnt_vld=1.
REQ-007 SHALL have port: gnt_vld  output  1  high when any gnt bit is high.
REQ-008 SHALL have port: preempt  output  1  one-cycle pulse in the GAP cycle following a forced release.

Function
REQ-009 SHALL implement FSM states IDLE, GRANT, GAP.
REQ-010 SHALL, in IDLE, arbitrate on req; if any bit is set, latch winner as owner and go to GRANT; else stay in IDLE.
REQ-011 SHALL, without the Configuration macro, use fixed priority: req[3] > req[2] > req[1] > req[0].
REQ-012 SHALL register grant: gnt, gnt_id and gnt_vld are asserted in the first GRANT cycle, one clock after req is sampled.
REQ-013 SHALL, in GRANT, drive gnt = one-hot(owner), gnt_id = owner, gnt_vld = 1, and count hold_cnt from 1 in the first GRANT cycle.
REQ-014 SHALL leave GRANT for GAP when req[owner]=0 is sampled (normal release).
REQ-015 SHALL leave GRANT for GAP with preempt flag set when hold_cnt==MAX_HOLD and any other req bit is set (forced release).
REQ-016 SHALL stay in GRANT past MAX_HOLD while no other requester is pending; hold_cnt saturates at MAX_HOLD.
REQ-017 SHALL, in GAP, drive gnt=0 and gnt_vld=0 for exactly one cycle, then arbitrate: winner -> GRANT, no req -> IDLE.
REQ-018 SHALL, in the GAP after a forced release, exclude the preempted owner from arbitration if any other req bit is set.
REQ-019 SHALL assert preempt only in the GAP cycle following a forced release.
REQ-020 SHALL ignore req changes of non-owners during GRANT; no mid-grant switching to a higher-priority requester.
REQ-021 SHALL hold gnt_id at its last value when gnt_vld=0.
REQ-022 SHALL never assert more than one gnt bit in any cycle.

Reset
REQ-023 SHALL, on rst_n=0, immediately (asynchronously) force state=IDLE, gnt=0, gnt_id=0, gnt_vld=0, preempt=0, hold_cnt=0, owner=0, last_owner=0.
REQ-024 SHALL, if reset is asserted mid-GRANT, drop gnt at once with no GAP cycle.
REQ-025 SHALL resume arbitration in IDLE on the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL support macro PRIORITY_ARBITER_ROUND_ROBIN_EN.
REQ-027 SHALL, when PRIORITY_ARBITER_ROUND_ROBIN_EN is defined, search requests starting at index (last_owner-1) mod 4 and descending with wrap.
REQ-028 SHALL, in round-robin mode, update last_owner on every grant; reset value 0 gives search order 3,2,1,0, matching fixed priority.
REQ-029 SHALL, when PRIORITY_ARBITER_ROUND_ROBIN_EN is undefined, use fixed priority per REQ-011 and not implement last_owner.
REQ-030 SHALL apply REQ-018 exclusion in both modes.

Verification
REQ-031 SHALL cover: req=0110 from IDLE -> next cycle gnt=0100, gnt_id=2; req[2] drops -> one GAP cycle with gnt=0 -> gnt=0010.
REQ-032 SHALL cover: MAX_HOLD=4, req=1001 held -> gnt=1000 for 4 cycles, GAP with preempt=1, then gnt=0001.
REQ-033 SHALL cover: MAX_HOLD=4, req=1000 alone for 10 cycles -> gnt=1000 throughout, preempt=0.
REQ-034 SHALL cover: req=0001 granted, then req=1001 -> gnt stays 0001 until req[0] drops.
REQ-035 SHALL cover: rst_n low mid-GRANT -> gnt=0, gnt_vld=0 in the same cycle; after release with req=0010 -> gnt=0010 one cycle later.
REQ-036 SHALL cover, with PRIORITY_ARBITER_ROUND_ROBIN_EN: req=1111 with each grant released after 1 cycle -> gnt sequence 1000, 0100, 0010, 0001, 1000.
